// File: rtl/rom_port_arbiter.sv
// ---------------------------------------------------------------------------
// rom_port_arbiter
//
// Shares one single-port synchronous program ROM (64 KB x 8) among three
// requesters: the HPS download writer (dl), the main CPU fetch port (cpu)
// and the sound CPU fetch port (snd). Downloads have absolute priority;
// cpu and snd are served round-robin. One grant per cycle, up to three
// transactions in flight, each completing two edges after its grant.
//
// Ports
//   clk_sys, reset_n          system clock, asynchronous active-low reset
//   dl_mode                   download window; holds off cpu/snd grants
//   dl_req/addr/data, dl_ack  download write port (ack = 1-cycle pulse)
//   cpu_req/addr, cpu_dout, cpu_ack   main CPU read port
//   snd_req/addr, snd_dout, snd_ack   sound CPU read port
//   ram_addr/we/d, ram_q      registered ROM controls, ROM read data
//   cpu_wait_cnt, snd_wait_cnt        contention counters
//
// Configuration
//   ROM_ARB_STATS_EN  when defined, the wait counters count cycles where a
//                     read port is eligible but not granted (saturating);
//                     when undefined they are tied to zero.
// ---------------------------------------------------------------------------
module rom_port_arbiter #(
   parameter int                 AW       = 16,
   parameter int                 SW       = 14,
   parameter logic [AW-SW-1:0]   SND_BASE = 2'b11
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          dl_mode,
   input  logic          dl_req,
   input  logic [24:0]   dl_addr,
   input  logic [7:0]    dl_data,
   output logic          dl_ack,
   input  logic          cpu_req,
   input  logic [AW-1:0] cpu_addr,
   output logic [7:0]    cpu_dout,
   output logic          cpu_ack,
   input  logic          snd_req,
   input  logic [SW-1:0] snd_addr,
   output logic [7:0]    snd_dout,
   output logic          snd_ack,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [7:0]    ram_d,
   input  logic [7:0]    ram_q,
   output logic [15:0]   cpu_wait_cnt,
   output logic [15:0]   snd_wait_cnt
);

   typedef enum logic [1:0] {TAG_NONE, TAG_DL, TAG_CPU, TAG_SND} tag_e;

   tag_e          grant;
   tag_e          tag_s1_q, tag_s1_d, tag_s2_q;
   logic          dl_busy_q, dl_busy_d;
   logic          cpu_busy_q, cpu_busy_d;
   logic          snd_busy_q, snd_busy_d;
   logic          rr_q, rr_d;          // 0: cpu preferred, 1: snd preferred
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic          ram_we_q, ram_we_d;
   logic [7:0]    ram_d_q, ram_d_d;
   logic [7:0]    cpu_dout_q, cpu_dout_d;
   logic [7:0]    snd_dout_q, snd_dout_d;
   logic          dl_ack_q, dl_ack_d;
   logic          cpu_ack_q, cpu_ack_d;
   logic          snd_ack_q, snd_ack_d;

   logic dl_elig, cpu_elig, snd_elig;

   assign dl_elig  = dl_req  & ~dl_busy_q;
   assign cpu_elig = cpu_req & ~cpu_busy_q;
   assign snd_elig = snd_req & ~snd_busy_q;

   // Arbitration. rr always ends up pointing away from whichever read port
   // was just granted, even when that port was the only contender.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      grant = TAG_NONE;
      rr_d  = rr_q;
      if (dl_elig) begin
         grant = TAG_DL;
      end else if (!dl_mode) begin
         if (cpu_elig && snd_elig) grant = rr_q ? TAG_SND : TAG_CPU;
         else if (cpu_elig)        grant = TAG_CPU;
         else if (snd_elig)        grant = TAG_SND;
      end
      if (grant == TAG_CPU)      rr_d = 1'b1;
      else if (grant == TAG_SND) rr_d = 1'b0;
   end

   // Grant issue and completion. A port cannot complete and be regranted on
   // the same edge because busy is still set while its tag is in stage 2.
   always_comb begin
      tag_s1_d   = grant;
      ram_addr_d = ram_addr_q;
      ram_we_d   = 1'b0;
      ram_d_d    = ram_d_q;
      dl_busy_d  = dl_busy_q;
      cpu_busy_d = cpu_busy_q;
      snd_busy_d = snd_busy_q;
      cpu_dout_d = cpu_dout_q;
      snd_dout_d = snd_dout_q;
      dl_ack_d   = 1'b0;
      cpu_ack_d  = 1'b0;
      snd_ack_d  = 1'b0;

      unique case (tag_s2_q)
         TAG_DL:  begin dl_ack_d  = 1'b1; dl_busy_d  = 1'b0; end
         TAG_CPU: begin cpu_ack_d = 1'b1; cpu_busy_d = 1'b0; cpu_dout_d = ram_q; end
         TAG_SND: begin snd_ack_d = 1'b1; snd_busy_d = 1'b0; snd_dout_d = ram_q; end
         default: ;
      endcase

      unique case (grant)
         TAG_DL: begin
            ram_addr_d = dl_addr[AW-1:0];
            ram_d_d    = dl_data;
            // Addresses beyond the ROM are acknowledged but never written.
            ram_we_d   = (dl_addr[24:AW] == '0);
            dl_busy_d  = 1'b1;
         end
         TAG_CPU: begin
            ram_addr_d = cpu_addr;
            cpu_busy_d = 1'b1;
         end
         TAG_SND: begin
            ram_addr_d = {SND_BASE, snd_addr};
            snd_busy_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         tag_s1_q   <= TAG_NONE;
         tag_s2_q   <= TAG_NONE;
         dl_busy_q  <= 1'b0;
         cpu_busy_q <= 1'b0;
         snd_busy_q <= 1'b0;
         rr_q       <= 1'b0;
         ram_addr_q <= '0;
         ram_we_q   <= 1'b0;
         ram_d_q    <= '0;
         cpu_dout_q <= '0;
         snd_dout_q <= '0;
         dl_ack_q   <= 1'b0;
         cpu_ack_q  <= 1'b0;
         snd_ack_q  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values, independent of statement order.
         tag_s1_q   <= tag_s1_d;
         tag_s2_q   <= tag_s1_q;
         dl_busy_q  <= dl_busy_d;
         cpu_busy_q <= cpu_busy_d;
         snd_busy_q <= snd_busy_d;
         rr_q       <= rr_d;
         ram_addr_q <= ram_addr_d;
         ram_we_q   <= ram_we_d;
         ram_d_q    <= ram_d_d;
         cpu_dout_q <= cpu_dout_d;
         snd_dout_q <= snd_dout_d;
         dl_ack_q   <= dl_ack_d;
         cpu_ack_q  <= cpu_ack_d;
         snd_ack_q  <= snd_ack_d;
      end
   end

   assign ram_addr = ram_addr_q;
   assign ram_we   = ram_we_q;
   assign ram_d    = ram_d_q;
   assign cpu_dout = cpu_dout_q;
   assign snd_dout = snd_dout_q;
   assign dl_ack   = dl_ack_q;
   assign cpu_ack  = cpu_ack_q;
   assign snd_ack  = snd_ack_q;

`ifdef ROM_ARB_STATS_EN
   logic [15:0] cpu_wait_q, snd_wait_q;

   // Cycles blocked by dl_mode count as waiting: the port is eligible.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cpu_wait_q <= '0;
         snd_wait_q <= '0;
      end else begin
         if (cpu_elig && (grant != TAG_CPU) && (cpu_wait_q != 16'hFFFF))
            cpu_wait_q <= cpu_wait_q + 16'd1;
         if (snd_elig && (grant != TAG_SND) && (snd_wait_q != 16'hFFFF))
            snd_wait_q <= snd_wait_q + 16'd1;
      end
   end

   assign cpu_wait_cnt = cpu_wait_q;
   assign snd_wait_cnt = snd_wait_q;
`else
   assign cpu_wait_cnt = '0;
   assign snd_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_port_arbiter
//
// Self-checking bench for rom_port_arbiter. A synchronous 64 KB ROM model
// sits on the ram_* port; locations never written read back a fixed hash of
// their address. Directed scenarios cover reset, single reads, round-robin,
// download preemption, out-of-range writes, reset mid-flight and the wait
// counters; a randomized run is checked against a timestamp-based model.
// ---------------------------------------------------------------------------
module tb_rom_port_arbiter;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        dl_mode, dl_req, dl_ack;
   logic [24:0] dl_addr;
   logic [7:0]  dl_data;
   logic        cpu_req, cpu_ack;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic        snd_req, snd_ack;
   logic [13:0] snd_addr;
   logic [7:0]  snd_dout;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_d, ram_q;
   logic [15:0] cpu_wait_cnt, snd_wait_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_sys = ~clk_sys;

   rom_port_arbiter #(.AW(16), .SW(14), .SND_BASE(2'b11)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .dl_mode(dl_mode),
      .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
      .snd_req(snd_req), .snd_addr(snd_addr), .snd_dout(snd_dout), .snd_ack(snd_ack),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q),
      .cpu_wait_cnt(cpu_wait_cnt), .snd_wait_cnt(snd_wait_cnt)
   );

   // ---------------- ROM array on the ram_* port ----------------
   logic [7:0]  rom     [65536];
   bit          r_valid [65536];
   logic        bd_we = 1'b0;
   logic [15:0] bd_addr = '0;
   logic [7:0]  bd_data = '0;

   function automatic logic [7:0] init_val(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] rom_rd(input logic [15:0] a);
      return r_valid[a] ? rom[a] : init_val(a);
   endfunction

   always @(posedge clk_sys) begin
      if (bd_we) begin
         rom[bd_addr] <= bd_data;
         r_valid[bd_addr] <= 1'b1;
      end else if (ram_we) begin
         rom[ram_addr] <= ram_d;
         r_valid[ram_addr] <= 1'b1;
      end
      ram_q <= rom_rd(ram_addr);
   end

   // ---------------- reference memory image ----------------
   logic [7:0] m_mem   [65536];
   bit         m_valid [65536];

   function automatic logic [7:0] m_rd(input logic [15:0] a);
      return m_valid[a] ? m_mem[a] : init_val(a);
   endfunction

   // ---------------- helpers (no checking) ----------------
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic idle_inputs();
      dl_mode = 1'b0; dl_req = 1'b0; dl_addr = '0; dl_data = '0;
      cpu_req = 1'b0; cpu_addr = '0; snd_req = 1'b0; snd_addr = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle_inputs();
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
      bd_addr = a; bd_data = d; bd_we = 1'b1;
      tick();
      bd_we = 1'b0;
      m_mem[a] = d;
      m_valid[a] = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      n_cmp++; if ({cpu_ack, snd_ack, dl_ack, ram_we} !== 4'b0) begin
         n_bad++; $display("FAIL reset_flags: got %b want 0000", {cpu_ack, snd_ack, dl_ack, ram_we}); end
      n_cmp++; if (ram_addr !== 16'h0000) begin
         n_bad++; $display("FAIL reset_ram_addr: got %h want 0000", ram_addr); end
      n_cmp++; if ({ram_d, cpu_dout, snd_dout} !== 24'h0) begin
         n_bad++; $display("FAIL reset_data: got %h want 000000", {ram_d, cpu_dout, snd_dout}); end
      n_cmp++; if ({cpu_wait_cnt, snd_wait_cnt} !== 32'h0) begin
         n_bad++; $display("FAIL reset_counters: got %h want 0", {cpu_wait_cnt, snd_wait_cnt}); end
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_single_read();
      logic [2:0] want;
      bd_write(16'h1234, 8'hA5);
      cpu_addr = 16'h1234;
      cpu_req  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k == 2) cpu_req = 1'b0;
         want = {(k == 2), 2'b00};
         n_cmp++; if ({cpu_ack, dl_ack, ram_we} !== want) begin
            n_bad++; $display("FAIL single_e%0d ack/we: got %b want %b", k, {cpu_ack, dl_ack, ram_we}, want); end
      end
      n_cmp++; if (ram_addr !== 16'h1234) begin
         n_bad++; $display("FAIL single_ram_addr: got %h want 1234", ram_addr); end
      n_cmp++; if (cpu_dout !== 8'hA5) begin
         n_bad++; $display("FAIL single_dout: got %h want a5", cpu_dout); end
      tick();
   endtask

   task automatic test_round_robin();
      int n_c, n_s;
      do_reset();
      cpu_addr = 16'h1234; snd_addr = 14'h0010;
      cpu_req = 1'b1; snd_req = 1'b1;
      tick();
      n_cmp++; if (ram_addr !== 16'h1234) begin
         n_bad++; $display("FAIL rr_first_grant: got %h want 1234", ram_addr); end
      tick();
      n_cmp++; if (ram_addr !== 16'hC010) begin
         n_bad++; $display("FAIL rr_second_grant: got %h want c010", ram_addr); end
      n_cmp++; if ({cpu_ack, snd_ack} !== 2'b00) begin
         n_bad++; $display("FAIL rr_e1_acks: got %b want 00", {cpu_ack, snd_ack}); end
      tick();
      n_cmp++; if ({cpu_ack, snd_ack} !== 2'b10 || cpu_dout !== m_rd(16'h1234)) begin
         n_bad++; $display("FAIL rr_e2: acks %b dout %h want 10 %h", {cpu_ack, snd_ack}, cpu_dout, m_rd(16'h1234)); end
      tick();
      n_cmp++; if ({cpu_ack, snd_ack} !== 2'b01 || snd_dout !== m_rd(16'hC010)) begin
         n_bad++; $display("FAIL rr_e3: acks %b dout %h want 01 %h", {cpu_ack, snd_ack}, snd_dout, m_rd(16'hC010)); end
      n_c = 1; n_s = 1;
      for (int k = 4; k < 32; k++) begin
         tick();
         n_c += int'(cpu_ack);
         n_s += int'(snd_ack);
      end
      n_cmp++; if (n_c != 10 || n_s != 10) begin
         n_bad++; $display("FAIL rr_30cycle_acks: got cpu %0d snd %0d want 10 10", n_c, n_s); end
      cpu_req = 1'b0; snd_req = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_download();
      int n_dl, n_cpu;
      n_dl = 0; n_cpu = 0;
      dl_mode = 1'b1; cpu_addr = 16'h0100; cpu_req = 1'b1;
      dl_addr = 25'd0; dl_data = 8'h10; dl_req = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         n_cmp++; if (dl_ack !== ((k % 3) == 2)) begin
            n_bad++; $display("FAIL dl_ack_e%0d: got %b want %b", k, dl_ack, (k % 3) == 2); end
         n_cpu += int'(cpu_ack);
         if (dl_ack) begin
            n_dl++;
            if (n_dl == 4) dl_req = 1'b0;
            dl_addr = 25'(n_dl);
            dl_data = 8'h10 + 8'(n_dl);
         end
      end
      n_cmp++; if (n_cpu != 0) begin
         n_bad++; $display("FAIL dl_cpu_held: got %0d cpu acks want 0", n_cpu); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (rom_rd(16'(i)) !== 8'h10 + 8'(i)) begin
            n_bad++; $display("FAIL dl_rom[%0d]: got %h want %h", i, rom_rd(16'(i)), 8'h10 + 8'(i)); end
         m_mem[i] = 8'h10 + 8'(i);
         m_valid[i] = 1'b1;
      end
      dl_mode = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++; if (cpu_ack !== (k == 2)) begin
            n_bad++; $display("FAIL dl_release_e%0d cpu_ack: got %b want %b", k, cpu_ack, k == 2); end
      end
      n_cmp++; if (cpu_dout !== m_rd(16'h0100)) begin
         n_bad++; $display("FAIL dl_release_dout: got %h want %h", cpu_dout, m_rd(16'h0100)); end
      cpu_req = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_out_of_range();
      dl_mode = 1'b1; dl_addr = 25'h10000; dl_data = 8'hFF; dl_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k == 2) dl_req = 1'b0;
         n_cmp++; if ({dl_ack, ram_we} !== {k == 2, 1'b0}) begin
            n_bad++; $display("FAIL oor_e%0d ack/we: got %b want %b", k, {dl_ack, ram_we}, {k == 2, 1'b0}); end
      end
      n_cmp++; if (rom_rd(16'h0000) !== m_rd(16'h0000)) begin
         n_bad++; $display("FAIL oor_rom0: got %h want %h", rom_rd(16'h0000), m_rd(16'h0000)); end
      dl_mode = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      cpu_addr = 16'h1234; cpu_req = 1'b1;
      repeat (3) tick();
      n_cmp++; if (cpu_ack !== 1'b1 || cpu_dout !== 8'hA5) begin
         n_bad++; $display("FAIL rmid_pre: ack %b dout %h want 1 a5", cpu_ack, cpu_dout); end
      cpu_req = 1'b0;
      tick();
      cpu_addr = 16'h0010; cpu_req = 1'b1;
      tick();                         // grant
      tick();                         // one cycle later
      reset_n = 1'b0;
      #1;
      n_cmp++; if ({cpu_ack, snd_ack, dl_ack, ram_we} !== 4'b0 || cpu_dout !== 8'h00) begin
         n_bad++; $display("FAIL rmid_async: flags %b dout %h want 0000 00", {cpu_ack, snd_ack, dl_ack, ram_we}, cpu_dout); end
      tick();
      tick();
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++; if (cpu_ack !== (k == 2)) begin
            n_bad++; $display("FAIL rmid_after_e%0d: cpu_ack %b want %b", k, cpu_ack, k == 2); end
      end
      n_cmp++; if (cpu_dout !== m_rd(16'h0010)) begin
         n_bad++; $display("FAIL rmid_dout: got %h want %h", cpu_dout, m_rd(16'h0010)); end
      cpu_req = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_stats();
      logic [15:0] want;
`ifdef ROM_ARB_STATS_EN
      want = 16'd100;
`else
      want = 16'd0;
`endif
      do_reset();
      dl_mode = 1'b1; cpu_addr = 16'h2000; cpu_req = 1'b1;
      repeat (100) tick();
      n_cmp++; if (cpu_wait_cnt !== want) begin
         n_bad++; $display("FAIL stats_cpu_wait: got %0d want %0d", cpu_wait_cnt, want); end
      n_cmp++; if (snd_wait_cnt !== 16'd0) begin
         n_bad++; $display("FAIL stats_snd_wait: got %0d want 0", snd_wait_cnt); end
      cpu_req = 1'b0; dl_mode = 1'b0;
      tick();
   endtask

   // Randomized traffic. The model tracks, per port, the edge index from
   // which it may be granted again and the edge at which its ack is due.
   task automatic test_random();
      int ok_dl, ok_cpu, ok_snd, due_dl, due_cpu, due_snd, g, w_cpu, w_snd;
      bit el_dl, el_cpu, el_snd, pref_snd, x_we, x_dack, x_cack, x_sack;
      bit out_dl, out_cpu, out_snd;
      logic [7:0]  dat_cpu, dat_snd, x_cdout, x_sdout, x_rd;
      logic [15:0] x_addr, a;
      logic [15:0] want_cpu_w, want_snd_w;
      do_reset();
      ok_dl = 0; ok_cpu = 0; ok_snd = 0; due_dl = -1; due_cpu = -1; due_snd = -1;
      w_cpu = 0; w_snd = 0; pref_snd = 1'b0;
      out_dl = 1'b0; out_cpu = 1'b0; out_snd = 1'b0;
      dat_cpu = '0; dat_snd = '0; x_cdout = '0; x_sdout = '0; x_rd = '0; x_addr = '0;
      for (int e = 0; e < 3000; e++) begin
         el_dl  = dl_req  && (e >= ok_dl);
         el_cpu = cpu_req && (e >= ok_cpu);
         el_snd = snd_req && (e >= ok_snd);
         g = 0;
         if (el_dl) g = 1;
         else if (!dl_mode) begin
            if (el_cpu && el_snd) g = pref_snd ? 3 : 2;
            else if (el_cpu)      g = 2;
            else if (el_snd)      g = 3;
         end
         if (el_cpu && g != 2 && w_cpu < 65535) w_cpu++;
         if (el_snd && g != 3 && w_snd < 65535) w_snd++;
         x_we = 1'b0;
         case (g)
            1: begin
               ok_dl = e + 3; due_dl = e + 2;
               x_addr = dl_addr[15:0]; x_rd = dl_data;
               if (dl_addr[24:16] == 9'd0) begin
                  x_we = 1'b1;
                  m_mem[dl_addr[15:0]] = dl_data;
                  m_valid[dl_addr[15:0]] = 1'b1;
               end
            end
            2: begin
               ok_cpu = e + 3; due_cpu = e + 2; x_addr = cpu_addr;
               dat_cpu = m_rd(cpu_addr); pref_snd = 1'b1;
            end
            3: begin
               a = {2'b11, snd_addr};
               ok_snd = e + 3; due_snd = e + 2; x_addr = a;
               dat_snd = m_rd(a); pref_snd = 1'b0;
            end
            default: ;
         endcase
         x_dack = (due_dl == e);
         x_cack = (due_cpu == e);
         x_sack = (due_snd == e);
         if (x_cack) x_cdout = dat_cpu;
         if (x_sack) x_sdout = dat_snd;

         tick();

         n_cmp++; if ({cpu_ack, snd_ack, dl_ack, ram_we} !== {x_cack, x_sack, x_dack, x_we}) begin
            n_bad++;
            if (n_bad < 20) $display("FAIL rand_e%0d flags: got %b want %b", e,
                                     {cpu_ack, snd_ack, dl_ack, ram_we}, {x_cack, x_sack, x_dack, x_we});
         end
         n_cmp++; if ({ram_addr, ram_d} !== {x_addr, x_rd}) begin
            n_bad++;
            if (n_bad < 20) $display("FAIL rand_e%0d ram_addr/d: got %h want %h", e, {ram_addr, ram_d}, {x_addr, x_rd});
         end
         n_cmp++; if ({cpu_dout, snd_dout} !== {x_cdout, x_sdout}) begin
            n_bad++;
            if (n_bad < 20) $display("FAIL rand_e%0d douts: got %h want %h", e, {cpu_dout, snd_dout}, {x_cdout, x_sdout});
         end

         // Requesters hold req/address until ack, then choose afresh.
         if (out_cpu && x_cack) out_cpu = 1'b0;
         if (!out_cpu) begin
            if ($urandom_range(0, 3) != 0) begin
               cpu_req = 1'b1; cpu_addr = 16'($urandom); out_cpu = 1'b1;
            end else cpu_req = 1'b0;
         end
         if (out_snd && x_sack) out_snd = 1'b0;
         if (!out_snd) begin
            if ($urandom_range(0, 3) != 0) begin
               snd_req = 1'b1; snd_addr = 14'($urandom); out_snd = 1'b1;
            end else snd_req = 1'b0;
         end
         if (out_dl && x_dack) out_dl = 1'b0;
         if (!out_dl) begin
            if (!dl_mode) begin
               dl_req = 1'b0;
               if ($urandom_range(0, 49) == 0) dl_mode = 1'b1;
            end else if ($urandom_range(0, 19) == 0) begin
               dl_mode = 1'b0; dl_req = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
               dl_req = 1'b1; out_dl = 1'b1; dl_data = 8'($urandom);
               if ($urandom_range(0, 7) == 0) dl_addr = {9'($urandom_range(1, 511)), 16'($urandom)};
               else                           dl_addr = {9'd0, 16'($urandom)};
            end else dl_req = 1'b0;
         end
      end
`ifdef ROM_ARB_STATS_EN
      want_cpu_w = 16'(w_cpu);
      want_snd_w = 16'(w_snd);
`else
      want_cpu_w = 16'd0;
      want_snd_w = 16'd0;
`endif
      n_cmp++; if ({cpu_wait_cnt, snd_wait_cnt} !== {want_cpu_w, want_snd_w}) begin
         n_bad++; $display("FAIL rand_wait_cnt: got %0d/%0d want %0d/%0d",
                           cpu_wait_cnt, snd_wait_cnt, want_cpu_w, want_snd_w); end
      idle_inputs();
      repeat (4) tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_download();
      test_out_of_range();
      test_reset_mid();
      test_stats();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
